// File: rtl/branch_unit.sv
// Execute-stage branch resolution: evaluates the branch condition, computes the
// resolved next PC, flags mispredictions and keeps saturating retire counters.
module branch_unit #(
    parameter int XLEN       = 64,
    parameter int CNT_W      = 32,
    parameter int ILEN_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  REG1,
    input  logic [XLEN-1:0]  REG2,
    input  logic [2:0]       Type,
    input  logic [XLEN-1:0]  PC,
    input  logic [XLEN-1:0]  IMM,
    input  logic             PredT,
    input  logic [XLEN-1:0]  PredPC,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             BrE,
    output logic             Mispred,
    output logic [XLEN-1:0]  RedirPC,
    output logic [CNT_W-1:0] BrCnt,
    output logic [CNT_W-1:0] MisCnt
);

    logic            taken;
    logic            mis_next;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fall_through;
    logic            accept;
    logic            retire;

    always_comb begin
        taken = 1'b0;
        case (Type)
            3'b010:  taken = (REG1 == REG2);
            3'b011:  taken = (REG1 != REG2);
            3'b100:  taken = ($signed(REG1) <  $signed(REG2));
            3'b101:  taken = ($signed(REG1) >= $signed(REG2));
            3'b110:  taken = (REG1 <  REG2);
            3'b111:  taken = (REG1 >= REG2);
            default: taken = 1'b0;
        endcase
    end

    assign target       = PC + IMM;
    assign fall_through = PC + XLEN'(ILEN_BYTES);

    // The predicted target only matters when both sides agree the branch is taken.
    assign mis_next = (taken != PredT) || (taken && PredT && (PredPC != target));

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            BrE       <= 1'b0;
            Mispred   <= 1'b0;
            RedirPC   <= '0;
        end else begin
            if (accept) begin
                BrE     <= taken;
                Mispred <= mis_next;
                RedirPC <= taken ? target : fall_through;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Counters stick at all-ones; a clear wins over a same-cycle retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BrCnt  <= '0;
            MisCnt <= '0;
        end else if (cnt_clr) begin
            BrCnt  <= '0;
            MisCnt <= '0;
        end else if (retire) begin
            if (BrCnt != '1) begin
                BrCnt <= BrCnt + CNT_W'(1);
            end
            if (Mispred && (MisCnt != '1)) begin
                MisCnt <= MisCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: the driver pushes model results on accept,
// a negedge monitor pops them on retire/flush and tracks the counters.
module tb_branch_unit;

    typedef struct {
        logic        bre;
        logic        mis;
        logic [63:0] redir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ready_s;
    logic [63:0] REG1 = '0, REG2 = '0, PC = '0, IMM = '0, PredPC = '0;
    logic [2:0]  Type = '0;
    logic        PredT = 1'b0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, BrE, Mispred;
    logic        out_valid_s, BrE_s, Mispred_s;
    logic [63:0] RedirPC, RedirPC_s;
    logic [31:0] BrCnt, MisCnt;
    logic [1:0]  BrCnt_s, MisCnt_s;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    bit   occ = 1'b0;
    longint br_model = 0;
    longint mis_model = 0;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(64), .CNT_W(32), .ILEN_BYTES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .REG1(REG1), .REG2(REG2), .Type(Type), .PC(PC), .IMM(IMM),
        .PredT(PredT), .PredPC(PredPC), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_ready(out_ready), .BrE(BrE),
        .Mispred(Mispred), .RedirPC(RedirPC), .BrCnt(BrCnt), .MisCnt(MisCnt)
    );

    // Narrow-counter copy on the same stimulus, used to exercise saturation.
    branch_unit #(.XLEN(64), .CNT_W(2), .ILEN_BYTES(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .REG1(REG1), .REG2(REG2), .Type(Type), .PC(PC), .IMM(IMM),
        .PredT(PredT), .PredPC(PredPC), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid_s), .out_ready(out_ready), .BrE(BrE_s),
        .Mispred(Mispred_s), .RedirPC(RedirPC_s), .BrCnt(BrCnt_s), .MisCnt(MisCnt_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [2:0] t, input logic [63:0] r1, r2,
                                       input logic [63:0] pc, imm, input logic pt,
                                       input logic [63:0] pp);
        exp_t   e;
        bit     tk;
        longint s1, s2;
        logic [63:0] tgt;
        s1 = r1;
        s2 = r2;
        case (t)
            3'd2:    tk = (r1 == r2);
            3'd3:    tk = (r1 != r2);
            3'd4:    tk = (s1 < s2);
            3'd5:    tk = !(s1 < s2);
            3'd6:    tk = (r1 < r2);
            3'd7:    tk = !(r1 < r2);
            default: tk = 1'b0;
        endcase
        tgt     = pc + imm;
        e.bre   = tk;
        e.redir = tk ? tgt : pc + 64'd4;
        e.mis   = tk ? (!pt || (pp != tgt)) : pt;
        return e;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Called at posedge+1; drives one cycle of stimulus and records any accept.
    task automatic issue(input logic v, input logic [2:0] t, input logic [63:0] r1, r2,
                         input logic [63:0] pc, imm, input logic pt, input logic [63:0] pp,
                         input logic ordy, input logic fl, input logic clr);
        bit   acc;
        bit   ret;
        exp_t e;
        in_valid = v; Type = t; REG1 = r1; REG2 = r2; PC = pc; IMM = imm;
        PredT = pt; PredPC = pp; out_ready = ordy; flush = fl; cnt_clr = clr;
        @(negedge clk);
        acc = v && (!occ || ordy) && !fl;
        ret = occ && ordy && !fl;
        e   = ref_model(t, r1, r2, pc, imm, pt, pp);
        if (fl)       occ = 1'b0;
        else if (acc) occ = 1'b1;
        else if (ret) occ = 1'b0;
        @(posedge clk);
        if (acc) q.push_back(e);
        $display("txn v=%0b t=%0d r1=%h r2=%h pc=%h imm=%h pt=%0b rdy=%0b fl=%0b clr=%0b acc=%0b",
                 v, t, r1, r2, pc, imm, pt, ordy, fl, clr, acc);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic clr);
        issue(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0, ordy, 1'b0, clr);
    endtask

    // Called at posedge+1; asserts rst mid-cycle and checks the immediate effect.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_brcnt", BrCnt, '0);
        check("rst_miscnt", MisCnt, '0);
        check("rst_brcnt_small", BrCnt_s, '0);
        occ = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   had;
        if (rst) begin
            br_model  = 0;
            mis_model = 0;
        end else begin
            had = 1'b0;
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, (q.size() == 0) || out_ready);
            check("out_valid_small", out_valid_s, q.size() != 0);
            check("brcnt", BrCnt, sat(br_model, 64'hFFFF_FFFF));
            check("miscnt", MisCnt, sat(mis_model, 64'hFFFF_FFFF));
            check("brcnt_small", BrCnt_s, sat(br_model, 3));
            check("miscnt_small", MisCnt_s, sat(mis_model, 3));
            if (q.size() != 0 && (out_ready || flush)) begin
                e   = q.pop_front();
                had = 1'b1;
                check("bre", BrE, e.bre);
                check("mispred", Mispred, e.mis);
                check("redir_pc", RedirPC, e.redir);
            end
            if (cnt_clr) begin
                br_model  = 0;
                mis_model = 0;
            end else if (had && out_ready && !flush) begin
                br_model++;
                if (e.mis) mis_model++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r1, r2, pc, imm, pp;
        logic [2:0]  t;
        logic        pt;
        @(posedge clk);
        #1;
        do_reset();

        // Signed vs unsigned less-than on the same operands.
        issue(1'b1, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h2000, 64'h10, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h2000, 64'h10, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        // Target mismatch and correctly predicted fall-through.
        issue(1'b1, 3'b010, 64'd5, 64'd5, 64'h1000, 64'h40, 1'b1, 64'h1080, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 3'b010, 64'd5, 64'd6, 64'h1000, 64'h40, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        // PC wrap-around for both taken and fall-through.
        issue(1'b1, 3'b011, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b1, 64'd4, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 3'b011, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);

        // Backpressure for three cycles, then flush, then a 4-deep stream.
        issue(1'b1, 3'b101, 64'd7, 64'd3, 64'h3000, 64'h20, 1'b1, 64'h3020, 1'b1, 1'b0, 1'b0);
        repeat (3) issue(1'b1, 3'b111, 64'd1, 64'd9, 64'h3100, 64'h8, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b111, 64'd1, 64'd9, 64'h3100, 64'h8, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            issue(1'b1, 3'(2 + i), 64'(i), 64'd2, 64'(32'h4000 + 16 * i), 64'h100, i[0], 64'h4100, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        #3;
        check("stream_brcnt", BrCnt, 64'd4);
        #2;

        // Saturation of the narrow counters.
        @(posedge clk);
        #1;
        idle(1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            issue(1'b1, 3'b000, 64'(i), 64'd0, 64'h5000, 64'h4, 1'b1, 64'h5004, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        #3;
        check("sat_brcnt_small", BrCnt_s, 64'd3);
        check("sat_miscnt_small", MisCnt_s, 64'd3);
        check("sat_brcnt_wide", BrCnt, 64'd5);
        #2;
        @(posedge clk);
        #1;
        issue(1'b1, 3'b000, '0, '0, 64'h6000, 64'h4, 1'b1, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        #3;
        check("clr_brcnt_small", BrCnt_s, 64'd0);
        check("clr_miscnt_small", MisCnt_s, 64'd0);
        #2;
        @(posedge clk);
        #1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r1  = {$urandom, $urandom};
            r2  = ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r2 = r1 ^ 64'h8000_0000_0000_0000;
            pc  = {$urandom, $urandom} & ~64'h3;
            imm = 64'($signed({$urandom_range(0, 8191), 1'b0}) - 64'sd8192);
            t   = 3'($urandom_range(0, 7));
            pt  = 1'($urandom);
            pp  = ($urandom_range(0, 1) == 0) ? pc + imm : {$urandom, $urandom};
            issue(1'($urandom_range(0, 3) != 0), t, r1, r2, pc, imm, pt, pp,
                  1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 31) == 0));
        end

        // Reset while a result is stalled at the output.
        issue(1'b1, 3'b010, 64'd1, 64'd1, 64'h7000, 64'h10, 1'b1, 64'h7010, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        do_reset();
        issue(1'b1, 3'b110, 64'd1, 64'd2, 64'h8000, 64'h10, 1'b1, 64'h8010, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised, pipelined branch resolution unit for the RV core's execute stage.
- Evaluates the branch condition on XLEN-bit operands and computes the resolved next PC.
- Checks the resolved outcome against the fetch-stage prediction and raises a mispredict/redirect.
- Registers the result behind a valid/ready handshake and keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- XLEN, 64: operand, PC and immediate width.
- CNT_W, 32: width of each performance counter.
- ILEN_BYTES, 4: fall-through PC increment.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- REG1  input  XLEN  source operand 1.
- REG2  input  XLEN  source operand 2.
- Type  input  3  branch type (funct3-derived encoding, see Behaviour).
- PC  input  XLEN  branch instruction address.
- IMM  input  XLEN  sign-extended branch offset.
- PredT  input  1  predicted taken.
- PredPC  input  XLEN  predicted target; meaningful only when PredT=1.
- flush  input  1  kill the in-flight result and ignore this cycle's request.
- cnt_clr  input  1  synchronous clear of both counters.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- BrE  output  1  branch taken (registered).
- Mispred  output  1  prediction wrong (registered).
- RedirPC  output  XLEN  resolved next PC (registered).
- BrCnt  output  CNT_W  retired branch count.
- MisCnt  output  CNT_W  retired mispredict count.

Behaviour:
- Reset (async, rst=1): out_valid=0, BrE=0, Mispred=0, RedirPC=0, BrCnt=0, MisCnt=0. Release is synchronous to the clk edge.
- Type encoding:
  - 010 BEQ (equal).
  - 011 BNE (not equal).
  - 100 BLT (signed less than).
  - 101 BGE (signed greater or equal).
  - 110 BLTU (unsigned less than).
  - 111 BGEU (unsigned greater or equal).
  - 000 and 001: not taken, still checked against the prediction.
- Target:
  - taken target T = PC+IMM, modulo 2^XLEN (wraps, no overflow flag).
  - fall-through F = PC+ILEN_BYTES, modulo 2^XLEN.
- Next PC: RedirPC = BrE ? T : F.
- Mispred = (BrE != PredT) OR (BrE AND PredT AND PredPC != T). PredPC is ignored when PredT=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid buffer).
  - accept = in_valid && in_ready && !flush.
  - On accept, BrE/Mispred/RedirPC/out_valid=1 load at the next edge. Latency is 1 cycle.
  - Outputs hold stable while out_valid && !out_ready.
  - retire = out_valid && out_ready && !flush.
  - If retire occurs with no accept, out_valid clears.
  - Retire and accept in the same cycle: the new result loads (back-to-back throughput of 1 per cycle).
- flush:
  - Next edge: out_valid=0. This cycle's input is not accepted and the pending result is not retired or counted.
  - BrE/Mispred/RedirPC may hold stale values while out_valid=0.
- Counters:
  - On retire: BrCnt += 1; MisCnt += 1 if Mispred.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority over increment. The same-cycle retire is not counted.
- rst asserted mid-transfer: the in-flight result is discarded, all state returns to reset values immediately.
- No combinational path from REG1/REG2 to outputs. All result outputs are registered.

Test Plan:
- Reset then idle: assert rst mid-cycle -> out_valid=0, BrCnt=MisCnt=0 immediately, in_ready=1.
- BLT signed vs BLTU: REG1=64'hFFFF_FFFF_FFFF_FFFF, REG2=1, Type=100 -> BrE=1. Type=110 -> BrE=0. Each result arrives one cycle after accept.
- Mispredict, target mismatch: PC=0x1000, IMM=0x40, Type=010, REG1=REG2=5, PredT=1, PredPC=0x1080 -> BrE=1, Mispred=1, RedirPC=0x1040. Not-taken case with PredT=0, REG1≠REG2 -> Mispred=0, RedirPC=0x1004.
- Wrap-around: PC=64'hFFFF_FFFF_FFFF_FFFC, Type=011 with REG1≠REG2, IMM=8 -> RedirPC=4. With REG1=REG2 -> RedirPC=0.
- Backpressure and flush:
  - Hold out_ready=0 for 3 cycles -> in_ready=0, outputs stable, no count.
  - Then assert flush -> out_valid=0, BrCnt unchanged.
  - Then stream 4 back-to-back requests with out_ready=1 -> 4 results on consecutive cycles, BrCnt=4.
- Saturation and clear: with CNT_W=2, retire 5 mispredicted branches -> BrCnt=MisCnt=3. Assert cnt_clr together with a retire -> both counters 0.
